// File: rtl/portal_rsp_arbiter_if.sv
// R-channel bundle: two per-source read-data queues in, one registered AXI R beat out.
// The master side drives request beats and consumer ready; the slave side is the arbiter.
interface portal_rsp_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_enq__ENA;
    logic [1:0][DATA_WIDTH-1:0] req_enq_data;
    logic [1:0][ID_WIDTH-1:0]   req_enq_id;
    logic [1:0]                 req_enq_last;
    logic [1:0]                 req_enq__RDY;

    logic                       out_enq__ENA;
    logic [DATA_WIDTH-1:0]      out_enq_data;
    logic [ID_WIDTH-1:0]        out_enq_id;
    logic                       out_enq_last;
    logic [1:0]                 out_enq_resp;
    logic                       out_enq__RDY;

    modport master (
        output req_valid,
        output req_enq__ENA,
        output req_enq_data,
        output req_enq_id,
        output req_enq_last,
        input  req_enq__RDY,
        input  out_enq__ENA,
        input  out_enq_data,
        input  out_enq_id,
        input  out_enq_last,
        input  out_enq_resp,
        output out_enq__RDY
    );

    modport slave (
        input  req_valid,
        input  req_enq__ENA,
        input  req_enq_data,
        input  req_enq_id,
        input  req_enq_last,
        output req_enq__RDY,
        output out_enq__ENA,
        output out_enq_data,
        output out_enq_id,
        output out_enq_last,
        output out_enq_resp,
        input  out_enq__RDY
    );
endinterface

// File: rtl/portal_rsp_arbiter.sv
// Burst-locked round-robin arbiter of two R-data sources onto one registered R beat (1-cycle latency).
// Source ready is combinational from consumer ready, so a full stage drains and reloads in one cycle.
module portal_rsp_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int MAX_BEATS  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    portal_rsp_arbiter_if.slave    bus,
    input  logic                   err_clr,
    output logic                   err,
    output logic                   err_src,
    output logic [15:0]            burst_cnt0,
    output logic [15:0]            burst_cnt1
);
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_grant;
    logic                   last_grant_nxt;
    logic [CW-1:0]          beat_cnt;
    logic [CW-1:0]          beat_num;

    logic                   full;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [ID_WIDTH-1:0]    out_id;
    logic                   out_last;
    logic [1:0]             out_resp;

    logic                   drain;
    logic                   can_load;
    logic                   winner;
    logic [1:0]             rdy;
    logic [1:0]             acc;
    logic                   any_acc;
    logic                   sel;
    logic                   in_last;
    logic                   overrun;
    logic                   burst_end;

    // Grant and acceptance decode; next-state follows from the accepted beat only.
    always_comb begin
        drain    = full & bus.out_enq__RDY;
        can_load = ~full | drain;

        if (bus.req_valid == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = bus.req_valid[1];
        end

        rdy[0] = can_load & (((state == IDLE) & ~winner & bus.req_valid[0]) | (state == LOCK0));
        rdy[1] = can_load & (((state == IDLE) &  winner & bus.req_valid[1]) | (state == LOCK1));

        acc      = bus.req_enq__ENA & rdy;
        any_acc  = |acc;
        sel      = acc[1];
        in_last  = sel ? bus.req_enq_last[1] : bus.req_enq_last[0];
        beat_num = beat_cnt + CW'(1);

        // The MAX_BEATS-th beat without last is closed off as the end of the burst.
        overrun   = any_acc & ~in_last & (beat_num == CW'(MAX_BEATS));
        burst_end = any_acc & (in_last | overrun);

        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (burst_end) begin
            state_nxt      = IDLE;
            last_grant_nxt = sel;
        end else if (any_acc) begin
            state_nxt = sel ? LOCK1 : LOCK0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (burst_end) begin
                beat_cnt <= '0;
            end else if (any_acc) begin
                beat_cnt <= beat_num;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full     <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            out_last <= 1'b0;
            out_resp <= 2'd0;
        end else if (any_acc) begin
            full     <= 1'b1;
            out_data <= sel ? bus.req_enq_data[1] : bus.req_enq_data[0];
            out_id   <= sel ? bus.req_enq_id[1]   : bus.req_enq_id[0];
            out_last <= in_last | overrun;
            out_resp <= overrun ? 2'd2 : 2'd0;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            burst_cnt0 <= 16'd0;
            burst_cnt1 <= 16'd0;
            err        <= 1'b0;
            err_src    <= 1'b0;
        end else begin
            if (burst_end & ~sel) begin
                burst_cnt0 <= burst_cnt0 + 16'd1;
            end
            if (burst_end & sel) begin
                burst_cnt1 <= burst_cnt1 + 16'd1;
            end
            // A fresh overrun outranks a simultaneous clear.
            if (overrun) begin
                err     <= 1'b1;
                err_src <= sel;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.req_enq__RDY = rdy;
    assign bus.out_enq__ENA = full;
    assign bus.out_enq_data = out_data;
    assign bus.out_enq_id   = out_id;
    assign bus.out_enq_last = out_last;
    assign bus.out_enq_resp = out_resp;

endmodule

// File: tb/tb_portal_rsp_arbiter.sv
// Bench for portal_rsp_arbiter: reset/grant vector table, directed burst sequences and a random
// run, all scored against a queue-based model of the expected R beat stream.
`timescale 1ns/1ps
module tb_portal_rsp_arbiter;
    localparam int DW = 32;
    localparam int IW = 6;
    localparam int MB = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        err_clr;
    logic        err;
    logic        err_src;
    logic [15:0] burst_cnt0;
    logic [15:0] burst_cnt1;

    always #5 CLK = ~CLK;

    portal_rsp_arbiter_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    portal_rsp_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BEATS(MB)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus.slave),
        .err_clr    (err_clr),
        .err        (err),
        .err_src    (err_src),
        .burst_cnt0 (burst_cnt0),
        .burst_cnt1 (burst_cnt1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
        logic [1:0]    resp;
    } beat_t;

    typedef struct {
        logic v0;
        logic v1;
        logic ordy;
        logic e0;
        logic e1;
    } vec_t;

    // Model: expected output stage contents as a queue, plus burst ownership and bookkeeping.
    beat_t       mq[$];
    int          m_owner;
    logic        m_lg;
    int          m_cnt;
    int          m_bc[2];
    logic        m_err;
    logic        m_err_src;

    // Source generators: pending beat per source and position within its burst.
    logic [DW-1:0] cur_data[2];
    logic [IW-1:0] cur_id[2];
    int            gen_len[2];
    int            gen_pos[2];
    bit            rand_len;
    bit            clr_on_ovr;
    int            acc_log[$];

    int checks;
    int passed;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic new_beat(input int n);
        cur_data[n] = $urandom;
        cur_id[n]   = IW'($urandom_range(0, 63));
    endtask

    task automatic model_reset();
        mq.delete();
        m_owner   = -1;
        m_lg      = 1'b1;
        m_cnt     = 0;
        m_bc[0]   = 0;
        m_bc[1]   = 0;
        m_err     = 1'b0;
        m_err_src = 1'b0;
        gen_pos[0] = 0;
        gen_pos[1] = 0;
    endtask

    task automatic do_reset(input bit expect_full);
        @(negedge CLK);
        if (expect_full) check("pre_rst_full", bus.out_enq__ENA, 1'b1);
        RST              = 1'b1;
        bus.req_valid    = 2'b00;
        bus.req_enq__ENA = 2'b00;
        err_clr          = 1'b0;
        #1;
        check("rst_out_vld", bus.out_enq__ENA, 1'b0);
        check("rst_out_data", bus.out_enq_data, '0);
        check("rst_rdy", bus.req_enq__RDY, 2'b00);
        check("rst_bc0", burst_cnt0, 16'd0);
        check("rst_bc1", burst_cnt1, 16'd0);
        check("rst_err", err, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    // One clock: drive at negedge, check outputs and ready against the model, update model at posedge.
    task automatic cycle(input logic v0, input logic v1, input logic ordy, input logic clr_pulse);
        logic [1:0] v;
        logic [1:0] erdy;
        logic [1:0] ena;
        logic       room;
        logic       lst;
        logic       ovr;
        int         win;
        int         n;
        beat_t      b;

        @(negedge CLK);
        v = {v1, v0};
        bus.req_valid = v;
        for (int k = 0; k < 2; k++) begin
            bus.req_enq_data[k] = cur_data[k];
            bus.req_enq_id[k]   = cur_id[k];
            bus.req_enq_last[k] = (gen_pos[k] + 1 == gen_len[k]);
        end
        bus.out_enq__RDY = ordy;
        bus.req_enq__ENA = 2'b00;
        err_clr          = 1'b0;
        #1;

        check("out_vld", bus.out_enq__ENA, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_data", bus.out_enq_data, mq[0].data);
            check("out_id", bus.out_enq_id, mq[0].id);
            check("out_last", bus.out_enq_last, mq[0].last);
            check("out_resp", bus.out_enq_resp, mq[0].resp);
        end
        check("err", err, m_err);
        if (m_err) check("err_src", err_src, m_err_src);
        check("bc0", burst_cnt0, 64'(m_bc[0] & 'hFFFF));
        check("bc1", burst_cnt1, 64'(m_bc[1] & 'hFFFF));

        room = (mq.size() == 0) || ordy;
        win  = (v == 2'b11) ? (m_lg ? 0 : 1) : (v[1] ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            erdy[k] = room && (m_owner == k || (m_owner < 0 && v[k] && win == k));
        end
        check("rdy0", bus.req_enq__RDY[0], erdy[0]);
        check("rdy1", bus.req_enq__RDY[1], erdy[1]);

        ena = v & bus.req_enq__RDY;
        n   = ena[1] ? 1 : 0;
        bus.req_enq__ENA = ena;
        err_clr = clr_pulse || (clr_on_ovr && ena != 2'b00 && gen_pos[n] == MB - 1);
        lst = bus.req_enq_last[n];

        @(posedge CLK);
        if (ordy && mq.size() != 0) void'(mq.pop_front());
        ovr = 1'b0;
        if (ena != 2'b00) begin
            m_cnt++;
            b.data = cur_data[n];
            b.id   = cur_id[n];
            b.last = lst;
            b.resp = 2'd0;
            if (!lst && m_cnt == MB) begin
                ovr    = 1'b1;
                b.last = 1'b1;
                b.resp = 2'd2;
            end
            mq.push_back(b);
            if (b.last) begin
                m_owner = -1;
                m_lg    = n[0];
                m_bc[n] = (m_bc[n] + 1) & 'hFFFF;
                m_cnt   = 0;
            end else begin
                m_owner = n;
            end
            acc_log.push_back(n);
            gen_pos[n]++;
            if (lst) begin
                gen_pos[n] = 0;
                if (rand_len) gen_len[n] = $urandom_range(1, 20);
            end
            new_beat(n);
        end else begin
            acc_log.push_back(-1);
        end
        if (ovr) begin
            m_err     = 1'b1;
            m_err_src = n[0];
        end else if (err_clr) begin
            m_err = 1'b0;
        end
    endtask

    task automatic check_log(input string nm, input int exp[]);
        for (int k = 0; k < exp.size(); k++) begin
            if (k < acc_log.size()) check(nm, 64'(acc_log[k]), 64'(exp[k]));
            else check(nm, 64'(-2), 64'(exp[k]));
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        checks = 0;
        passed = 0;
        RST              = 1'b1;
        err_clr          = 1'b0;
        bus.req_valid    = 2'b00;
        bus.req_enq__ENA = 2'b00;
        bus.req_enq_data = '0;
        bus.req_enq_id   = '0;
        bus.req_enq_last = 2'b00;
        bus.out_enq__RDY = 1'b0;
        rand_len   = 1'b0;
        clr_on_ovr = 1'b0;
        gen_len[0] = 1;
        gen_len[1] = 1;
        new_beat(0);
        new_beat(1);
        do_reset(1'b0);

        // Idle grant table: empty stage, source 0 wins the first tie.
        foreach (vecs[i]) begin
            @(negedge CLK);
            bus.req_valid    = {vecs[i].v1, vecs[i].v0};
            bus.out_enq__RDY = vecs[i].ordy;
            bus.req_enq__ENA = 2'b00;
            #1;
            check("vec_rdy0", bus.req_enq__RDY[0], vecs[i].e0);
            check("vec_rdy1", bus.req_enq__RDY[1], vecs[i].e1);
        end

        // Single beat from source 0.
        gen_len[0]  = 1;
        cur_data[0] = 32'h11;
        cur_id[0]   = 6'd3;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("t1_vld", bus.out_enq__ENA, 1'b1);
        check("t1_data", bus.out_enq_data, 32'h11);
        check("t1_id", bus.out_enq_id, 6'd3);
        check("t1_resp", bus.out_enq_resp, 2'd0);
        check("t1_bc0", burst_cnt0, 16'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Alternating 4-beat bursts at full rate.
        do_reset(1'b0);
        gen_len[0] = 4;
        gen_len[1] = 4;
        acc_log.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_log("rr_order", '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1});

        // Source 1 holds the lock while source 0 waits.
        do_reset(1'b0);
        acc_log.delete();
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_log("lock_hold", '{1, 1, 1, 1, 0, 0});

        // Consumer stall with the stage full, then drain and load together.
        acc_log.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_log("stall", '{-1, -1, -1, -1, -1, 0});

        // Runaway burst, clear, then overrun coinciding with clear.
        do_reset(1'b0);
        gen_len[0] = 20;
        for (int i = 0; i < MB; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("ovr_last", bus.out_enq_last, 1'b1);
        check("ovr_resp", bus.out_enq_resp, 2'd2);
        check("ovr_err", err, 1'b1);
        check("ovr_err_src", err_src, 1'b0);
        check("ovr_bc0", burst_cnt0, 16'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("clr_err", err, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        gen_len[1] = MB + 1;
        clr_on_ovr = 1'b1;
        for (int i = 0; i < MB; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        clr_on_ovr = 1'b0;
        #1;
        check("ovr_clr_err", err, 1'b1);
        check("ovr_clr_src", err_src, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-burst with the stage full; next tie goes to source 0.
        do_reset(1'b0);
        gen_len[1] = 4;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset(1'b1);
        acc_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_log("post_rst_tie", '{0});

        // Random traffic against the model.
        do_reset(1'b0);
        rand_len   = 1'b1;
        gen_len[0] = $urandom_range(1, 20);
        gen_len[1] = $urandom_range(1, 20);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 30) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/portal_rsp_arbiter.md
# portal_rsp_arbiter

Burst-locked round-robin arbiter sharing the MAXIGP0 AXI read-data (R) return channel between two response sources: the portal control/register read path (source 0) and the user indication path (source 1). It sits between the per-source read-data FIFOs and the AXI R port of the portal top level. Once a burst starts, it holds the channel for that source until the last beat, with a one-entry registered output stage and a runaway-burst guard. It also provides per-source burst counters for debug readout.

## Interface
- DATA_WIDTH, 32, R data width
- ID_WIDTH, 6, AXI transaction id width
- MAX_BEATS, 16, beat limit per burst before forced termination (power of 2, ≤256)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- reqN$valid  in  1  (N=0,1) source N has a beat pending
- reqN$enq__ENA  in  1  beat transfer; asserted only while reqN$enq__RDY
- reqN$enq$data  in  DATA_WIDTH  beat data
- reqN$enq$id  in  ID_WIDTH  beat id
- reqN$enq$last  in  1  final beat of burst
- reqN$enq__RDY  out  1  source N granted and stage can accept
- out$enq__ENA  out  1  output stage holds a valid beat
- out$enq$data / $id / $last  out  DATA_WIDTH / ID_WIDTH / 1  registered beat
- out$enq$resp  out  2  0 = OKAY, 2 = SLVERR (forced termination)
- out$enq__RDY  in  1  R consumer accepts; transfer = out$enq__ENA & out$enq__RDY
- err_clr  in  1  clears err
- err  out  1  sticky: a burst exceeded MAX_BEATS
- err_src  out  1  source of the most recent error
- burst_cnt0, burst_cnt1  out  16  completed bursts per source, wrapping

## Operation
- State: IDLE, LOCK0, LOCK1; last_grant bit; beat counter (width log2(MAX_BEATS)+1); 1-entry output register (full flag).
- can_load = !full | (out$enq__ENA & out$enq__RDY).
- IDLE winner: the only valid source; if both are valid, the source != last_grant.
- reqN$enq__RDY = can_load & ((state==IDLE & winner==N & reqN$valid) | state==LOCKN). At most one RDY is high.
- Accepted beat: load data/id/last/resp=0 into the output register; full=1; beat counter +1.
- Transitions on an accepted beat from source N with last=0: IDLE→LOCKN, LOCKN stays.
- Transitions on an accepted beat with last=1: →IDLE, last_grant=N, burst_cntN+1, beat counter=0.
- Runaway guard: when the accepted beat is number MAX_BEATS and last=0, output last=1, resp=2; treat the beat as burst end (→IDLE, last_grant=N, burst_cntN+1, counter=0); err=1, err_src=N. Later beats from that source form a new burst.
- Output drained without reload: full=0.
- err_clr and a new error in the same cycle: the error wins (err stays 1).
- Source deasserting valid while in LOCKN: the lock holds; the other source waits.

## Timing
- Reset values: out$enq__ENA=0; out data/id/last/resp=0; both RDY=0 after reset until evaluated (combinational from state); state=IDLE; last_grant=1 (source 0 wins the first tie); counters=0; err=0; err_src=0.
- Latency: accepted beat appears on out$enq__ENA the next cycle.
- Throughput: 1 beat/cycle when out$enq__RDY is held high. reqN$enq__RDY depends combinationally on out$enq__RDY, so dequeue and load can occur in the same cycle.
- Burst switch: a new IDLE grant occurs the cycle after the last beat is accepted. There is no bubble on the output if the stage is being drained.
- RST asserted mid-burst: all state clears immediately; the in-flight output beat is dropped; no partial-burst recovery.
- burst_cntN wraps 0xFFFF→0.

## Test plan
- Reset, then req0 single beat (data=0x11, id=3, last=1) → out$enq__ENA next cycle with data 0x11, id 3, resp 0; burst_cnt0=1.
- Both valid continuously, each sending 4-beat bursts, with out$enq__RDY=1 → order is src0 burst, src1 burst, src0 burst; no interleaving; 1 beat/cycle.
- src1 locked mid-burst (2 of 4 beats sent), src0 valid → req0$enq__RDY stays 0 until src1 last is accepted; src0 is granted on the next cycle.
- out$enq__RDY=0 for 5 cycles with the stage full → both RDY=0, out beat held stable; on release, drain and load in the same cycle.
- src0 sends MAX_BEATS=16 beats with last=0 → the 16th beat outputs last=1, resp=2; err=1, err_src=0. err_clr pulse → err=0; err_clr in the same cycle as a second overrun → err=1.
- RST pulse during a src1 burst with the stage full → out$enq__ENA=0 immediately, state IDLE, counters 0. The next tie grants src0.
